// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg: state encoding and word geometry shared by the program loader.
package inst_mem_loader_pkg;
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
    localparam int WORD_BITS = 32;
    localparam int BYTES_PER_WORD = WORD_BITS / 8;
endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// inst_mem_loader_byte_packer: little-endian byte-lane insert register with a 2-bit lane counter.
module inst_mem_loader_byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load_en,
    input  logic [7:0]           byte_in,
    output logic [WORD_BITS-1:0] word,
    output logic                 full
);
    logic [1:0]           r_lane;
    logic [WORD_BITS-1:0] r_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_lane <= '0;
        end else if (load_en) begin
            r_word[{r_lane, 3'b000} +: 8] <= byte_in;
            r_lane                        <= r_lane + 2'd1;
        end
    end

    // full flags the load that completes the word, so the FSM can leave RECV on that same edge
    assign word = r_word;
    assign full = load_en && (r_lane == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: packs a byte stream into words and drives the instruction-memory write port.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ILEN      = 32,
    parameter int MEM_SIZE  = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] length,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [ILEN-1:0] mem_wdata,
    output logic            mem_write_en,
    output logic            busy,
    output logic            done,
    output logic            error
);
    localparam logic [XLEN-1:0] LIMIT = XLEN'(MEM_SIZE - BASE_ADDR);
    localparam logic [XLEN-1:0] STEP  = XLEN'(BYTES_PER_WORD);
    localparam logic [XLEN-1:0] BASE  = XLEN'(BASE_ADDR);

    state_t          r_state;
    logic            r_ready;
    logic            r_we;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_remaining;
    logic            w_xfer;
    logic            w_full;
    logic            w_bad;
    logic [ILEN-1:0] w_word;

    assign w_xfer = byte_valid && r_ready;
    assign w_bad  = (length[1:0] != 2'b00) || (length > LIMIT);

    inst_mem_loader_byte_packer u_packer (
        .clock   (clock),
        .reset   (reset),
        .clear   (r_state == WRITE),
        .load_en (w_xfer),
        .byte_in (byte_in),
        .word    (w_word),
        .full    (w_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_addr      <= BASE;
            r_remaining <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_addr      <= BASE;
                        r_remaining <= length;
                        r_done      <= length == '0;
                        r_error     <= length != '0 && w_bad;
                        r_state     <= length == '0 ? DONE : (w_bad ? ERROR : RECV);
                        r_ready     <= length != '0 && !w_bad;
                        r_busy      <= length != '0 && !w_bad;
                    end
                end
                RECV: begin
                    if (w_full) begin
                        r_state <= WRITE;
                        r_ready <= 1'b0;
                        r_we    <= 1'b1;
                    end
                end
                WRITE: begin
                    r_addr      <= r_addr + STEP;
                    r_remaining <= r_remaining - STEP;
                    r_state     <= r_remaining == STEP ? DONE : RECV;
                    r_ready     <= r_remaining != STEP;
                    r_busy      <= r_remaining != STEP;
                    r_done      <= r_remaining == STEP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign byte_ready   = r_ready;
    assign mem_addr     = r_addr;
    assign mem_wdata    = w_word;
    assign mem_write_en = r_we;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed loads checked against an image-to-writes model and a memory shadow.
module tb_inst_mem_loader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] length = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write_en;
    logic        busy;
    logic        done;
    logic        error;

    int          tests = 0;
    int          fails = 0;
    int          n_writes = 0;
    int          w0;
    logic        prev_we = 1'b0;
    logic [31:0] mem [0:255];
    logic [7:0]  img [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];

    inst_mem_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .length       (length),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write_en (mem_write_en),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // model: an image of n bytes becomes n/4 little-endian words at consecutive addresses
    task automatic expect_image(input int n);
        for (int i = 0; i < n / 4; i++) begin
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back({img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
        end
    endtask

    task automatic pulse_start(input logic [31:0] len);
        start  = 1'b1;
        length = len;
        @(posedge clock); #1;
        start  = 1'b0;
    endtask

    task automatic send(input int first, input int n, input int gap);
        for (int k = first; k < first + n; k++) begin
            logic got;
            if (k != first)
                for (int g = 0; g < gap; g++) begin
                    @(posedge clock); #1;
                end
            byte_valid = 1'b1;
            byte_in    = img[k];
            got        = 1'b0;
            for (int t = 0; t < 64 && !got; t++) begin
                @(negedge clock);
                got = byte_ready;
                @(posedge clock); #1;
            end
            byte_valid = 1'b0;
            check("byte_accept", 32'(got), 1);
        end
    endtask

    always @(negedge clock) begin
        if (mem_write_en) begin
            check("we_one_cycle", 32'(prev_we), 0);
            n_writes++;
            mem[mem_addr[9:2]] = mem_wdata;
            if (exp_addr.size() == 0)
                check("unexpected_write", 32'(exp_addr.size()), 1);
            else begin
                check("wr_addr", mem_addr, exp_addr.pop_front());
                check("wr_data", mem_wdata, exp_data.pop_front());
            end
        end
        if (byte_ready)
            check("ready_implies_busy", 32'(busy), 1);
        prev_we = mem_write_en;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", 32'(byte_ready), 0);
        check("rst_we", 32'(mem_write_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);

        // full-rate two-word image
        img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        expect_image(8);
        w0 = n_writes;
        @(posedge clock); #1;
        pulse_start(8);
        send(0, 8, 0);
        @(negedge clock);
        check("a_we_last", 32'(mem_write_en), 1);
        check("a_addr_last", mem_addr, 32'h4);
        check("a_wdata_last", mem_wdata, 32'h00200593);
        check("a_done_early", 32'(done), 0);
        @(negedge clock);
        check("a_done", 32'(done), 1);
        check("a_busy", 32'(busy), 0);
        check("a_nwrites", 32'(n_writes - w0), 2);
        check("a_mem0", mem[0], 32'h00100513);
        check("a_mem1", mem[1], 32'h00200593);

        // same image, byte_valid every other cycle
        for (int i = 0; i < 256; i++) mem[i] = '0;
        expect_image(8);
        w0 = n_writes;
        pulse_start(8);
        send(0, 8, 1);
        @(negedge clock);
        check("b_we_last", 32'(mem_write_en), 1);
        @(negedge clock);
        check("b_done", 32'(done), 1);
        check("b_nwrites", 32'(n_writes - w0), 2);
        check("b_mem0", mem[0], 32'h00100513);
        check("b_mem1", mem[1], 32'h00200593);

        // bad lengths; stray bytes in ERROR are not taken
        w0 = n_writes;
        pulse_start(6);
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        @(negedge clock);
        check("e6_error", 32'(error), 1);
        check("e6_done", 32'(done), 0);
        check("e6_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("e6_ready", 32'(byte_ready), 0);
        end
        @(posedge clock); #1;
        byte_valid = 1'b0;
        pulse_start(1028);
        @(negedge clock);
        check("e1028_error", 32'(error), 1);
        check("e_nwrites", 32'(n_writes - w0), 0);

        // exactly MEM_SIZE is accepted
        @(posedge clock); #1;
        pulse_start(1024);
        @(negedge clock);
        check("m1024_error", 32'(error), 0);
        check("m1024_busy", 32'(busy), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;

        // reset mid-word discards the partial word
        w0  = n_writes;
        img = '{8'hAA, 8'hBB};
        pulse_start(4);
        send(0, 2, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("r_busy", 32'(busy), 0);
        check("r_ready", 32'(byte_ready), 0);
        check("r_nwrites", 32'(n_writes - w0), 0);
        img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        expect_image(4);
        @(posedge clock); #1;
        pulse_start(4);
        send(0, 4, 0);
        @(negedge clock);
        check("r_we", 32'(mem_write_en), 1);
        check("r_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clock);
        check("r_done", 32'(done), 1);
        check("r_mem0", mem[0], 32'hDEADBEEF);

        // reset wins over a simultaneous start
        @(posedge clock); #1;
        reset  = 1'b1;
        start  = 1'b1;
        length = 4;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("rs_busy", 32'(busy), 0);
        check("rs_done", 32'(done), 0);
        check("rs_ready", 32'(byte_ready), 0);

        // zero length completes immediately
        w0 = n_writes;
        @(posedge clock); #1;
        pulse_start(0);
        @(negedge clock);
        check("z_done", 32'(done), 1);
        check("z_busy", 32'(busy), 0);
        check("z_error", 32'(error), 0);
        check("z_nwrites", 32'(n_writes - w0), 0);

        // start during a load is ignored
        w0  = n_writes;
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        expect_image(8);
        @(posedge clock); #1;
        pulse_start(8);
        send(0, 3, 0);
        pulse_start(4);
        send(3, 5, 0);
        @(negedge clock);
        check("s_we", 32'(mem_write_en), 1);
        check("s_addr", mem_addr, 32'h4);
        check("s_wdata", mem_wdata, 32'h08070605);
        @(negedge clock);
        check("s_done", 32'(done), 1);
        check("s_nwrites", 32'(n_writes - w0), 2);
        check("s_mem0", mem[0], 32'h04030201);
        check("exp_drained", 32'(exp_addr.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer-side companion to the instruction memory. Receives a little-endian byte stream over a valid/ready handshake and packs it into ILEN-bit words.
- Drives the memory's address, write-data and write-enable inputs to load a program image before the core is released.
- Sits between the boot/debug byte source and the instruction-memory write port. The top level muxes mem_addr against the core PC while busy=1.

Parameters:
- XLEN, 32, address width.
- ILEN, 32, instruction/word width; must be 32 (4 bytes per word).
- MEM_SIZE, 1024, instruction-memory size in bytes.
- BASE_ADDR, 0, byte address of the first word written; multiple of 4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load in IDLE/DONE/ERROR.
- length  in  XLEN  image size in bytes, sampled on start.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte this cycle.
- mem_addr  out  XLEN  byte address to memory (pc input).
- mem_wdata  out  ILEN  assembled word.
- mem_write_en  out  1  one-cycle write strobe.
- busy  out  1  load in progress.
- done  out  1  image fully written; sticky until next start.
- error  out  1  bad length; sticky until next start.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values: state=IDLE, byte_ready=0, mem_write_en=0, busy=0, done=0, error=0, mem_addr=BASE_ADDR, mem_wdata=0, byte counter=0.
- States:
  - IDLE, DONE, ERROR: on start, latch length, clear done/error, set mem_addr=BASE_ADDR, then evaluate length.
    - If length==0, go to DONE.
    - Else if length[1:0]!=0 or length > MEM_SIZE-BASE_ADDR, go to ERROR.
    - Else go to RECV.
  - RECV: byte_ready=1. A transfer occurs when byte_valid && byte_ready.
    - Byte k (k=0..3 within the word) goes to mem_wdata[8k+7:8k]; the first byte received is the LSB.
    - Counter increments per transfer; no transfer means no change.
    - On the 4th transfer, go to WRITE.
  - WRITE: byte_ready=0; mem_write_en=1 for exactly this cycle; mem_addr and mem_wdata are stable.
    - Next cycle: mem_addr += 4, remaining -= 4, counter=0.
    - If remaining==0, go to DONE; else go to RECV.
  - DONE: done=1. ERROR: error=1. Both are held until the next start.
- busy=1 in RECV and WRITE only.
- Throughput: 5 cycles per word at full byte rate. The write lands on the clock edge ending WRITE.
- Boundaries:
  - start while busy is ignored.
  - byte_valid outside RECV is ignored; no byte is consumed.
  - The last word of the image is written at MEM_SIZE-4 at most, so there is no address wrap.
  - start and reset in the same cycle: reset wins.
  - Reset mid-load: the partial word is discarded, no write is issued, and the FSM returns to IDLE. Words already written remain in memory.
  - mem_addr is a registered output with no combinational path from byte_in.

Decomposition:
- Package inst_mem_loader_pkg holds:
  - typedef enum for the states {IDLE, RECV, WRITE, DONE, ERROR}.
  - BYTES_PER_WORD = ILEN/8.
- One sub-module, byte_packer. It is a byte-lane shift/insert register with a 2-bit lane counter, plus clear and load-enable inputs. It outputs the word and a full flag. The FSM and address/remaining counters stay in the top module.

Test Plan:
- Reset held 2 cycles -> all outputs at reset values; mem_addr=0; byte_ready=0.
- start, length=8; bytes 13,05,10,00,93,05,20,00 (hex) at one per cycle -> write 0x00100513 at addr 0, then 0x00200593 at addr 4, each mem_write_en exactly 1 cycle. done=1 the cycle after the second write. The memory reads back both words.
- Same image with byte_valid asserted every other cycle -> identical writes and addresses, exactly 2 write strobes, no dropped or duplicated bytes.
- start, length=6 -> error=1 next cycle; zero writes; byte_ready stays 0. start, length=MEM_SIZE+4 -> error=1.
- start, length=4; feed 2 bytes; assert reset -> no mem_write_en, state IDLE. Restart with length=4 and bytes EF,BE,AD,DE -> write 0xDEADBEEF at addr 0.
- start, length=0 -> done next cycle, no writes. start pulsed mid-load with length=8 -> ignored; the load completes with the original length.
